// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite position controller: bounces or nudges the sprite once per N frames, in blanking.
// Optional manual nudge logic is compiled in when SPRITE_MANUAL_EN is defined.
module sprite_motion_ctrl #(
   parameter int XMAX            = 156,
   parameter int YMAX            = 116,
   parameter int FRAMES_PER_STEP = 2,
   parameter int X_INIT          = 0,
   parameter int Y_INIT          = 0
) (
   input  logic       VGA_CLK,
   input  logic       resetn,
   input  logic [7:0] xvga,
   input  logic [6:0] yvga,
   input  logic       enable,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic       frame_tick,
   output logic       moving
);

   localparam logic [7:0] X_MAX     = 8'(XMAX);
   localparam logic [6:0] Y_MAX     = 7'(YMAX);
   localparam logic [7:0] FCNT_LAST = 8'(FRAMES_PER_STEP - 1);

   typedef enum logic [1:0] {IDLE, WAIT, STEP} state_t;

   state_t     state, state_next;
   logic [7:0] fcnt, fcnt_next;
   logic       last, last_q;
   logic       dx, dy, dx_next, dy_next;
   logic [7:0] x_next;
   logic [6:0] y_next;
   logic       req_l, req_r, req_u, req_d, manual;

   assign last   = (xvga == 8'd159) && (yvga == 7'd119);
   assign moving = (state != IDLE);

   // Edge-detect the last pixel so a held coordinate yields a single tick.
   always_ff @(posedge VGA_CLK or negedge resetn) begin
      if (!resetn) begin
         last_q     <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         last_q     <= last;
         frame_tick <= last & ~last_q;
      end
   end

   always_ff @(posedge VGA_CLK or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         fcnt  <= 8'd0;
      end else begin
         state <= state_next;
         fcnt  <= fcnt_next;
      end
   end

   always_comb begin
      state_next = state;
      fcnt_next  = fcnt;
      case (state)
         IDLE: begin
            fcnt_next = 8'd0;
            if (enable) state_next = WAIT;
         end
         WAIT: begin
            if (!enable) begin
               state_next = IDLE;
               fcnt_next  = 8'd0;
            end else if (frame_tick) begin
               if (fcnt == FCNT_LAST) begin
                  fcnt_next  = 8'd0;
                  state_next = STEP;
               end else begin
                  fcnt_next = fcnt + 8'd1;
               end
            end
         end
         STEP:    state_next = enable ? WAIT : IDLE;
         default: begin
            state_next = IDLE;
            fcnt_next  = 8'd0;
         end
      endcase
   end

`ifdef SPRITE_MANUAL_EN
   logic lat_l, lat_r, lat_u, lat_d;

   // A button held during STEP survives into the next step's latch.
   always_ff @(posedge VGA_CLK or negedge resetn) begin
      if (!resetn) begin
         {lat_l, lat_r, lat_u, lat_d} <= 4'b0;
      end else if (state != IDLE && state_next == IDLE) begin
         {lat_l, lat_r, lat_u, lat_d} <= 4'b0;
      end else if (state == STEP) begin
         {lat_l, lat_r, lat_u, lat_d} <= {btn_left, btn_right, btn_up, btn_down};
      end else begin
         {lat_l, lat_r, lat_u, lat_d} <= {lat_l | btn_left, lat_r | btn_right,
                                          lat_u | btn_up, lat_d | btn_down};
      end
   end

   assign {req_l, req_r, req_u, req_d} = {lat_l, lat_r, lat_u, lat_d};
`else
   logic unused_btn;
   assign unused_btn = ^{btn_left, btn_right, btn_up, btn_down};
   assign {req_l, req_r, req_u, req_d} = 4'b0;
`endif

   assign manual = req_l | req_r | req_u | req_d;

   always_comb begin
      x_next  = x;
      y_next  = y;
      dx_next = dx;
      dy_next = dy;
      if (manual) begin
         if (req_l && !req_r) begin
            x_next  = (x == 8'd0) ? 8'd0 : x - 8'd1;
            dx_next = 1'b0;
         end else if (req_r && !req_l) begin
            x_next  = (x >= X_MAX) ? X_MAX : x + 8'd1;
            dx_next = 1'b1;
         end
         if (req_u && !req_d) begin
            y_next  = (y == 7'd0) ? 7'd0 : y - 7'd1;
            dy_next = 1'b0;
         end else if (req_d && !req_u) begin
            y_next  = (y >= Y_MAX) ? Y_MAX : y + 7'd1;
            dy_next = 1'b1;
         end
      end else begin
         if (dx && x >= X_MAX) begin
            x_next  = X_MAX - 8'd1;
            dx_next = 1'b0;
         end else if (!dx && x == 8'd0) begin
            x_next  = 8'd1;
            dx_next = 1'b1;
         end else begin
            x_next = dx ? x + 8'd1 : x - 8'd1;
         end
         if (dy && y >= Y_MAX) begin
            y_next  = Y_MAX - 7'd1;
            dy_next = 1'b0;
         end else if (!dy && y == 7'd0) begin
            y_next  = 7'd1;
            dy_next = 1'b1;
         end else begin
            y_next = dy ? y + 7'd1 : y - 7'd1;
         end
      end
   end

   always_ff @(posedge VGA_CLK or negedge resetn) begin
      if (!resetn) begin
         x  <= 8'(X_INIT);
         y  <= 7'(Y_INIT);
         dx <= 1'b1;
         dy <= 1'b1;
      end else if (state == STEP) begin
         x  <= x_next;
         y  <= y_next;
         dx <= dx_next;
         dy <= dy_next;
      end
   end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Randomized scoreboard bench for sprite_motion_ctrl: synthetic frames, queue of expected ticks and moves.
// Follows SPRITE_MANUAL_EN so the reference model matches the build under test.
module tb_sprite_motion_ctrl;

   localparam int FPS    = 2;
   localparam int XM     = 156;
   localparam int YM     = 116;
   localparam int X_INIT = 0;
   localparam int Y_INIT = 0;

   logic       VGA_CLK = 1'b0;
   logic       resetn  = 1'b1;
   logic [7:0] xvga    = 8'd0;
   logic [6:0] yvga    = 7'd0;
   logic       enable  = 1'b0;
   logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [7:0] x;
   logic [6:0] y;
   logic       frame_tick, moving;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {int ex; int ey; int ecyc;} move_t;
   move_t posQ[$];
   int    tickQ[$];

   int       mx, my, mcnt;
   bit       mdx, mdy;
   bit [3:0] mlat;
   int       prevX, prevY;

   sprite_motion_ctrl #(
      .XMAX(XM), .YMAX(YM), .FRAMES_PER_STEP(FPS), .X_INIT(X_INIT), .Y_INIT(Y_INIT)
   ) dut (
      .VGA_CLK(VGA_CLK), .resetn(resetn), .xvga(xvga), .yvga(yvga), .enable(enable),
      .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
      .x(x), .y(y), .frame_tick(frame_tick), .moving(moving)
   );

   always #5 VGA_CLK = ~VGA_CLK;
   always @(posedge VGA_CLK) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic modelReset();
      mx = X_INIT; my = Y_INIT; mdx = 1'b1; mdy = 1'b1; mcnt = 0; mlat = 4'b0;
      posQ.delete();
      tickQ.delete();
   endtask

   // One pixel in the current direction; stepping outside [0,maxv] reflects back inward.
   function automatic int bounceNext(input int p, input bit d, input int maxv);
      int t;
      t = d ? p + 1 : p - 1;
      if (t < 0 || t > maxv) t = d ? p - 1 : p + 1;
      return t;
   endfunction

   task automatic modelStep(input int n);
      int ox, oy, nx, ny;
      bit manual;
      ox = mx; oy = my;
      manual = 1'b0;
`ifdef SPRITE_MANUAL_EN
      manual = (mlat != 4'b0);
`endif
      if (manual) begin
         if (mlat[3] && !mlat[2]) begin mx = (mx > 0) ? mx - 1 : 0; mdx = 1'b0; end
         else if (mlat[2] && !mlat[3]) begin mx = (mx < XM) ? mx + 1 : XM; mdx = 1'b1; end
         if (mlat[1] && !mlat[0]) begin my = (my > 0) ? my - 1 : 0; mdy = 1'b0; end
         else if (mlat[0] && !mlat[1]) begin my = (my < YM) ? my + 1 : YM; mdy = 1'b1; end
      end else begin
         nx = bounceNext(mx, mdx, XM);
         ny = bounceNext(my, mdy, YM);
         mdx = (nx > mx); mdy = (ny > my);
         mx = nx; my = ny;
      end
      mlat = 4'b0;
      if (mx != ox || my != oy) posQ.push_back('{mx, my, n + 2});
   endtask

   // Monitor: every tick and every position change must match the head of its queue.
   always @(posedge VGA_CLK) begin
      #2;
      if (!resetn) begin
         prevX = int'(x);
         prevY = int'(y);
      end else begin
         if (frame_tick) begin
            if (tickQ.size() == 0) checkOutput("tick_unexpected", cyc, -1);
            else checkOutput("tick_cycle", cyc, tickQ.pop_front());
         end
         if (int'(x) != prevX || int'(y) != prevY) begin
            if (posQ.size() == 0) begin
               checkOutput("move_unexpected", cyc, -1);
            end else begin
               move_t e;
               e = posQ.pop_front();
               checkOutput("pos_x", int'(x), e.ex);
               checkOutput("pos_y", int'(y), e.ey);
               checkOutput("pos_cycle", cyc, e.ecyc);
            end
            prevX = int'(x);
            prevY = int'(y);
         end
      end
   end

   task automatic driveIdle();
      @(negedge VGA_CLK);
      xvga = 8'($urandom_range(0, 159));
      yvga = 7'($urandom_range(0, 118));
   endtask

   task automatic applyStimulus(input bit en, input int hold, input bit doReset);
      int n;
      repeat (3) driveIdle();
      driveIdle();
      enable = en;
      if (!en) begin mcnt = 0; mlat = 4'b0; end
      driveIdle();
      checkOutput("moving", int'(moving), int'(en));
      if (doReset) begin
         @(negedge VGA_CLK);
         resetn = 1'b0;
         #1;
         checkOutput("async_reset_x", int'(x), X_INIT);
         checkOutput("async_reset_y", int'(y), Y_INIT);
         checkOutput("async_reset_moving", int'(moving), 0);
         checkOutput("async_reset_tick", int'(frame_tick), 0);
         modelReset();
         driveIdle();
         resetn = 1'b1;
      end
      if (en && $urandom_range(0, 3) == 0) begin
         driveIdle();
         {btn_left, btn_right, btn_up, btn_down} = 4'($urandom_range(1, 15));
         mlat |= {btn_left, btn_right, btn_up, btn_down};
         driveIdle();
         {btn_left, btn_right, btn_up, btn_down} = 4'b0;
      end
      driveIdle();
      @(negedge VGA_CLK);
      xvga = 8'd159;
      yvga = 7'd119;
      n = cyc + 1;
      tickQ.push_back(n);
      if (en) begin
         mcnt++;
         if (mcnt == FPS) begin
            mcnt = 0;
            modelStep(n);
         end
      end
      repeat (hold - 1) @(negedge VGA_CLK);
   endtask

   initial begin
      #1 resetn = 1'b0;
      #1;
      checkOutput("reset_x", int'(x), X_INIT);
      checkOutput("reset_y", int'(y), Y_INIT);
      checkOutput("reset_tick", int'(frame_tick), 0);
      checkOutput("reset_moving", int'(moving), 0);
      modelReset();
      repeat (3) @(negedge VGA_CLK);
      resetn = 1'b1;
      for (int f = 0; f < 800; f++) begin
         applyStimulus((f % 60) < 55, int'($urandom_range(1, 4)), f == 700);
      end
      repeat (8) driveIdle();
      checkOutput("pending_moves", posQ.size(), 0);
      checkOutput("pending_ticks", tickQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Frame-synchronous position controller for the 4×4 sprite on the 160×120 VGA XY display. It watches the scan coordinates, detects the end of each visible frame, and updates the sprite's `x`/`y` only during vertical blanking, so the sprite never tears mid-frame. Motion is either an autonomous diagonal bounce inside the display bounds or single-pixel manual nudges from push buttons. Its outputs drive the `x`/`y` inputs of the sprite compositor.

## Interface
- `XMAX`, default 156: largest legal sprite x (display width 160 − 4).
- `YMAX`, default 116: largest legal sprite y (display height 120 − 4).
- `FRAMES_PER_STEP`, default 2: frames per position step; range 1..255.
- `X_INIT`, default 0: reset x.
- `Y_INIT`, default 0: reset y.

- `VGA_CLK`  in  1  pixel clock. Single clock; all state is on its rising edge.
- `resetn`  in  1  reset. Asynchronous assert, active-low.
- `xvga`  in  8  current scan x, 0..159.
- `yvga`  in  7  current scan y, 0..119.
- `enable`  in  1  level; 1 = motion permitted.
- `btn_left`, `btn_right`, `btn_up`, `btn_down`  in  1 each  active-high nudge requests, already synchronized.
- `x`  out  8  sprite x, registered.
- `y`  out  7  sprite y, registered.
- `frame_tick`  out  1  one-cycle pulse per frame end.
- `moving`  out  1  high while state ≠ IDLE.

## Operation
- **Frame detect:** `last = (xvga==159) & (yvga==119)`. `last_q` is registered. `frame_tick <= last & ~last_q`, so the tick fires once per frame even when coordinates are held for several clocks.
- **Direction registers:** `dx`, `dy`, each 1 bit. 1 means +1, 0 means −1.
- **Frame counter:** `fcnt`, 8 bits.
- **State machine** (IDLE, WAIT, STEP):
  - IDLE: `fcnt = 0`. If `enable`, go to WAIT.
  - WAIT: if `~enable`, go to IDLE and clear `fcnt`. Otherwise, on `frame_tick`: if `fcnt == FRAMES_PER_STEP-1`, clear `fcnt` and go to STEP; else increment `fcnt`.
  - STEP: one cycle. Apply the update, then return to WAIT, or to IDLE if `~enable`.
- **Autonomous update** (STEP with no latched button):
  - x axis: if `dx=1` and `x==XMAX`, then `x <= XMAX-1` and `dx <= 0`. If `dx=0` and `x==0`, then `x <= 1` and `dx <= 1`. Otherwise `x <= x ± 1`.
  - y axis: same rule with `YMAX`.
  - Both axes update in the same cycle.
- **Manual update** (STEP with any latched button): autonomous motion is suppressed on both axes.
  - Per axis, exactly one latched direction moves 1 pixel that way, saturating at 0 or MAX, and sets `dx`/`dy` to that direction.
  - Both or neither direction latched on an axis: no movement on that axis, direction unchanged.
- **Button latches:** sticky, set by a high level on the button.
  - Cleared in STEP, except a button high during the STEP cycle stays latched for the next step.
  - Latches are also cleared on entry to IDLE.
- **Position invariant:** `x` never exceeds `XMAX` and `y` never exceeds `YMAX`. All arithmetic is unsigned at native width, with no wrap-around.
- **Reset values:**
  - `x = X_INIT`, `y = Y_INIT`
  - `dx = 1`, `dy = 1`
  - `fcnt = 0`, state = IDLE
  - `frame_tick = 0`, `moving = 0`, `last_q = 0`
  - All button latches = 0
- **Reset mid-operation:** takes effect immediately. A STEP in progress is discarded.

## Timing
- Cycle N: the first cycle with `last = 1`.
- Cycle N+1: `frame_tick = 1`.
- Cycle N+2: STEP (when `fcnt` matched).
- Cycle N+3: new `x`/`y` visible. Update latency is 3 clocks from frame end, well inside vertical blanking.
- `x`/`y` change at most once per `FRAMES_PER_STEP` frames and only in blanking.
- `enable` rising: the first step occurs on the `FRAMES_PER_STEP`-th tick after entering WAIT.
- `enable` falling during STEP: that update completes, then the FSM goes to IDLE.

## Configuration
- `SPRITE_MANUAL_EN` defined: button latches and manual-update logic are compiled in, as described above.
- `SPRITE_MANUAL_EN` undefined: button ports remain but are ignored, no latches exist, and every STEP is autonomous.

## Test plan
- **Reset and step rate:** reset, `enable=1`, `FRAMES_PER_STEP=2`, 6 synthetic frames → `x`/`y` go (0,0) → (1,1) → (2,2) → (3,3). Each change occurs exactly 3 clocks after the 2nd, 4th and 6th frame ends.
- **Bounce:** preload near the corner, `FRAMES_PER_STEP=1`. (155,115) steps to (156,116), then (155,115) with `dx=dy=0`. Separately, (0,0) with `dx=dy=0` steps to (1,1) with `dx=dy=1`.
- **Held coordinates:** hold (159,119) for 4 clocks → exactly one `frame_tick`.
- **Manual nudge** (`SPRITE_MANUAL_EN`): pulse `btn_left` 1 clock mid-frame at x=10 → next step x=9, y unchanged, `dx=0`. Also:
  - `btn_left`+`btn_right` together → x unchanged.
  - `btn_up` at y=0 → y stays 0.
- **Enable drop and async reset:**
  - `enable` low mid-WAIT → `moving=0`, position frozen across 3 frames.
  - `resetn` low mid-frame → `x=X_INIT` and `y=Y_INIT` immediately, without a clock edge.
